// File: rtl/addsub_rr_arbiter.sv
// Two-requester round-robin front end for a shared W-bit signed add/sub datapath.
// Build macro ADDSUB_ARB_SAT_EN: saturate rsp_s on signed overflow instead of wrapping.
module addsub_rr_arbiter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_sub,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_s,
  output logic         rsp_ovf,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_rr_ptr;

  logic [W-1:0] r_op_a;
  logic [W-1:0] r_op_b;
  logic         r_op_sub;
  logic         r_op_id;

  logic         r_rsp_valid;
  logic         r_rsp_id;
  logic [W-1:0] r_rsp_s;
  logic         r_rsp_ovf;

  logic         w_grant0;
  logic         w_grant1;
  logic         w_xfer;
  logic         w_gid;
  logic [W-1:0] w_sel_a;
  logic [W-1:0] w_sel_b;
  logic         w_sel_sub;
  logic [W-1:0] w_sum;
  logic         w_ovf;
  logic [W-1:0] w_res;

  // A lone valid always wins; a tie goes to the requester rr_ptr points at.
  assign w_grant0   = req0_valid & (~req1_valid | (r_rr_ptr == 1'b0));
  assign w_grant1   = req1_valid & (~req0_valid | (r_rr_ptr == 1'b1));
  assign req0_ready = (r_state == IDLE) & w_grant0;
  assign req1_ready = (r_state == IDLE) & w_grant1;
  assign w_xfer     = req0_ready | req1_ready;
  assign w_gid      = req1_ready;

  assign w_sel_a    = w_gid ? req1_a   : req0_a;
  assign w_sel_b    = w_gid ? req1_b   : req0_b;
  assign w_sel_sub  = w_gid ? req1_sub : req0_sub;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_xfer) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = HOLD;
      HOLD:    if (r_rsp_valid && rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_xfer) begin
      r_rr_ptr <= ~w_gid;
    end
  end

  // NOTE: operand registers carry no reset; they are only read in EXEC, after a load in IDLE.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_op_a   <= w_sel_a;
      r_op_b   <= w_sel_b;
      r_op_sub <= w_sel_sub;
      r_op_id  <= w_gid;
    end
  end

  always_comb begin
    w_sum = r_op_sub ? (r_op_a - r_op_b) : (r_op_a + r_op_b);
    w_ovf = 1'b0;
    if (r_op_sub) begin
      w_ovf = (r_op_a[W-1] != r_op_b[W-1]) & (w_sum[W-1] != r_op_a[W-1]);
    end else begin
      w_ovf = (r_op_a[W-1] == r_op_b[W-1]) & (w_sum[W-1] != r_op_a[W-1]);
    end
  end

`ifdef ADDSUB_ARB_SAT_EN
  // Overflow direction follows A's sign: positive A clamps high, negative A clamps low.
  always_comb begin
    w_res = w_sum;
    if (w_ovf) begin
      w_res = r_op_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign w_res = w_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_s     <= '0;
      r_rsp_ovf   <= 1'b0;
    end else if (r_state == EXEC) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= r_op_id;
      r_rsp_s     <= w_res;
      r_rsp_ovf   <= w_ovf;
    end else if ((r_state == HOLD) && r_rsp_valid && rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_s     = r_rsp_s;
  assign rsp_ovf   = r_rsp_ovf;
  assign busy      = (r_state != IDLE);

endmodule
